// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, mode encoding and Barrett helpers for the ML-KEM NTT butterfly datapath
package ntt_pkg;
    localparam int NTT_DW  = 12;
    localparam int NTT_Q   = 3329;
    localparam int INV2    = 1665;
    localparam int LATENCY = 4;
    typedef enum logic {MODE_NTT = 1'b0, MODE_INTT = 1'b1} mode_e;
    function automatic int barrett_k(input int dw);
        return 2 * dw + 2;
    endfunction
    function automatic longint unsigned barrett_m(input int q, input int dw);
        return longint'((longint'(1) << barrett_k(dw)) / longint'(q));
    endfunction
    localparam int              BARRETT_K = barrett_k(NTT_DW);
    localparam longint unsigned BARRETT_M = barrett_m(NTT_Q, NTT_DW);
endpackage

// File: rtl/mod_mul_barrett.sv
// mod_mul_barrett: two-stage (a*b) mod Q; stage 1 registers the full product, stage 2 the Barrett-reduced result.
// Ports: clk; i_en shared pipeline enable; i_a, i_b operands < Q; o_t result in [0, Q), valid two enabled edges later.
module mod_mul_barrett import ntt_pkg::*; #(
    parameter int DW = NTT_DW,
    parameter int Q  = NTT_Q
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_t
);
    localparam int              K  = barrett_k(DW);
    localparam int              PW = 2 * DW + K;
    localparam logic [PW-1:0]   M  = PW'(barrett_m(Q, DW));
    localparam logic [2*DW-1:0] QW = (2*DW)'(Q);
    logic [2*DW-1:0] r_p, w_q, w_r;
    logic [PW-1:0]   w_pm;
    logic [DW-1:0]   r_t;
    // K = 2*DW+2 keeps the quotient estimate at most one short, so one subtract suffices
    always_comb begin
        w_pm = PW'(r_p) * M;
        w_q  = (2*DW)'(w_pm >> K);
        w_r  = r_p - w_q * QW;
    end
    always_ff @(posedge clk)
        if (i_en) begin
            r_p <= {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};
            r_t <= w_r >= QW ? DW'(w_r - QW) : DW'(w_r);
        end
    assign o_t = r_t;
endmodule

// File: rtl/bu_ntt_pipe.sv
// bu_ntt_pipe: multi-lane pipelined NTT/INTT butterfly with valid/ready flow control and a global stall.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_mode/in_half/in_a/in_b/in_w input beat (lane 0 in LSBs);
//        out_valid/out_ready/out_a/out_b/out_mode output beat; busy = any stage holds a valid beat.
module bu_ntt_pipe import ntt_pkg::*; #(
    parameter int LANES = 1,
    parameter int DW    = NTT_DW,
    parameter int Q     = NTT_Q
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic              in_half,
    input  logic [LANES*DW-1:0] in_a,
    input  logic [LANES*DW-1:0] in_b,
    input  logic [LANES*DW-1:0] in_w,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANES*DW-1:0] out_a,
    output logic [LANES*DW-1:0] out_b,
    output logic              out_mode,
    output logic              busy
);
    localparam logic [DW:0] QE = (DW+1)'(Q);
    logic       w_en;
    logic [4:0] r_v, r_mode;
    logic [3:0] r_half;
    function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s >= QE ? DW'(s - QE) : DW'(s);
    endfunction
    function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] x, input logic [DW-1:0] y);
        return x >= y ? x - y : DW'({1'b0, x} + QE - {1'b0, y});
    endfunction
    // x * 2^-1 mod Q without a multiplier: odd values borrow one Q to become even
    function automatic logic [DW-1:0] halve(input logic [DW-1:0] x);
        return x[0] ? DW'(({1'b0, x} + QE) >> 1) : x >> 1;
    endfunction
    // whole pipeline freezes on output backpressure; bubbles are not compressed
    assign w_en      = !(r_v[4] && !out_ready);
    assign in_ready  = w_en;
    assign out_valid = r_v[4];
    assign out_mode  = r_mode[4];
    assign busy      = |r_v;
    always_ff @(posedge clk)
        if (rst) begin
            r_v    <= '0;
            r_mode <= '0;
            r_half <= '0;
        end else if (w_en) begin
            r_v    <= {r_v[3:0], in_valid};
            r_mode <= {r_mode[3:0], in_mode};
            r_half <= {r_half[2:0], in_half};
        end
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [DW-1:0] r_a0, r_b0, r_w0, r_a1, r_w1, r_x1, r_s1, r_a2, r_s2, r_a3, r_s3, r_oa, r_ob, w_t;
        always_ff @(posedge clk)
            if (w_en) begin
                r_a0 <= in_a[g*DW +: DW];
                r_b0 <= in_b[g*DW +: DW];
                r_w0 <= in_w[g*DW +: DW];
                r_a1 <= r_a0;
                r_w1 <= r_w0;
                r_s1 <= mod_add(r_a0, r_b0);
                r_x1 <= r_mode[0] == MODE_INTT ? mod_sub(r_a0, r_b0) : r_b0;
                r_a2 <= r_a1;
                r_s2 <= r_s1;
                r_a3 <= r_a2;
                r_s3 <= r_s2;
            end
        mod_mul_barrett #(.DW(DW), .Q(Q)) u_mul (
            .clk  (clk),
            .i_en (w_en),
            .i_a  (r_w1),
            .i_b  (r_x1),
            .o_t  (w_t)
        );
        // output registers load only real beats so they hold the last result between beats
        always_ff @(posedge clk)
            if (rst) begin
                r_oa <= '0;
                r_ob <= '0;
            end else if (w_en && r_v[3]) begin
                r_oa <= r_mode[3] == MODE_INTT ? (r_half[3] ? halve(r_s3) : r_s3) : mod_add(r_a3, w_t);
                r_ob <= r_mode[3] == MODE_INTT ? (r_half[3] ? halve(w_t) : w_t) : mod_sub(r_a3, w_t);
            end
        assign out_a[g*DW +: DW] = r_oa;
        assign out_b[g*DW +: DW] = r_ob;
    end
endmodule

// File: tb/tb_bu_ntt_pipe.sv
// tb_bu_ntt_pipe: directed and randomized self-checking bench for bu_ntt_pipe with four lanes
module tb_bu_ntt_pipe;
    import ntt_pkg::*;
    localparam int L  = 4;
    localparam int W  = 12;
    localparam int QQ = 3329;

    logic           clk = 0;
    logic           rst = 1;
    logic           in_valid = 0, in_mode = 0, in_half = 0, out_ready = 1;
    logic [L*W-1:0] in_a = '0, in_b = '0, in_w = '0;
    logic           in_ready, out_valid, out_mode, busy;
    logic [L*W-1:0] out_a, out_b;

    typedef struct packed {
        logic           mode;
        logic [L*W-1:0] a;
        logic [L*W-1:0] b;
    } beat_t;

    beat_t          exp_q[$];
    beat_t          mon_e;
    int             n_tests = 0, n_fail = 0;
    int             lat, cyc, sent, stalls, seen;
    logic           acc, prev_stall;
    logic [2*L*W:0] snap;

    bu_ntt_pipe #(.LANES(L), .DW(W), .Q(QQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_half   (in_half),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_mode  (out_mode),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic beat_t model(input logic m, input logic h, input logic [L*W-1:0] a, b, w);
        beat_t r;
        int x, y, z, t, ra, rb;
        r.mode = m;
        r.a = '0;
        r.b = '0;
        for (int i = 0; i < L; i++) begin
            x = int'(a[i*W +: W]);
            y = int'(b[i*W +: W]);
            z = int'(w[i*W +: W]);
            if (!m) begin
                t  = (z * y) % QQ;
                ra = (x + t) % QQ;
                rb = (x - t + QQ) % QQ;
            end else begin
                ra = (x + y) % QQ;
                rb = (z * ((x - y + QQ) % QQ)) % QQ;
                if (h) begin
                    ra = (ra * 1665) % QQ;
                    rb = (rb * 1665) % QQ;
                end
            end
            r.a[i*W +: W] = W'(ra);
            r.b[i*W +: W] = W'(rb);
        end
        return r;
    endfunction

    function automatic logic [L*W-1:0] rnd_lanes();
        logic [L*W-1:0] v;
        int             k;
        for (int i = 0; i < L; i++) begin
            k = $urandom_range(7);
            v[i*W +: W] = k == 0 ? W'(0) : k == 1 ? W'(QQ - 1) : W'($urandom_range(QQ - 1));
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // scoreboard: every accepted beat is modelled, every delivered beat must match the oldest
    always @(posedge clk) begin
        if (rst) exp_q.delete();
        else begin
            if (out_valid && out_ready) begin
                n_tests++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL sb_spurious: got beat %h expected none", {out_mode, out_a, out_b});
                end
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    assert ({out_mode, out_a, out_b} === mon_e) else begin
                        n_fail++;
                        $error("FAIL sb_beat: got %h expected %h", {out_mode, out_a, out_b}, mon_e);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_mode, in_half, in_a, in_b, in_w));
        end
    end

    task automatic one(input string tag, input logic m, input logic h, input logic [W-1:0] a, b, w,
                       input logic [W-1:0] ea, input logic [W-1:0] eb);
        out_ready = 1;
        in_valid = 1;
        in_mode = m;
        in_half = h;
        in_a = {12'd5, 12'd3328, 12'd0, a};
        in_b = {12'd3328, 12'd3328, 12'd0, b};
        in_w = {12'd1000, 12'd3328, 12'd0, w};
        #1;
        chk({tag, "_in_ready"}, 128'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(LATENCY));
        chk({tag, "_a"}, 128'(out_a[W-1:0]), 128'(ea));
        chk({tag, "_b"}, 128'(out_b[W-1:0]), 128'(eb));
        chk({tag, "_mode"}, 128'(out_mode), 128'(m));
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_in_ready", 128'(in_ready), 1);
        chk("rst_out_a", 128'(out_a), 0);
        chk("rst_out_b", 128'(out_b), 0);
        chk("rst_out_mode", 128'(out_mode), 0);
        in_valid = 0;
        rst = 0;
        @(posedge clk);
        #1;

        one("ntt_basic", 0, 0, 800, 3, 7, 821, 779);
        one("intt_nohalf", 1, 0, 12, 20, 3, 32, 3305);
        one("intt_half", 1, 1, 12, 20, 3, 16, 3317);
        one("ntt_wrap", 0, 0, 3328, 3328, 3328, 0, 3327);
        one("intt_wrap", 1, 0, 0, 1, 1, 1, 3328);
        one("ntt_half_ignored", 0, 1, 800, 3, 7, 821, 779);

        cyc = 0;
        sent = 0;
        stalls = 0;
        prev_stall = 0;
        snap = '0;
        while (sent < 10 && cyc < 100) begin
            in_valid = 1;
            in_mode = sent[0];
            in_half = sent[1];
            in_a = rnd_lanes();
            in_b = rnd_lanes();
            in_w = rnd_lanes();
            out_ready = !(cyc >= 6 && cyc < 9);
            #1;
            if (prev_stall) chk("bp_hold_payload", 128'({out_mode, out_a, out_b}), 128'(snap));
            if (out_valid && !out_ready) begin
                stalls++;
                chk("bp_in_ready_low", 128'(in_ready), 0);
                snap = {out_mode, out_a, out_b};
            end
            prev_stall = out_valid && !out_ready;
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) sent++;
        end
        in_valid = 0;
        out_ready = 1;
        chk("bp_sent", 128'(sent), 10);
        chk("bp_stall_cycles", 128'(stalls), 3);
        cyc = 0;
        while ((exp_q.size() != 0 || busy) && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("bp_drained", 128'(exp_q.size()), 0);

        in_valid = 1;
        repeat (3) begin
            in_mode = 0;
            in_a = rnd_lanes();
            in_b = rnd_lanes();
            in_w = rnd_lanes();
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        chk("midrst_out_valid", 128'(out_valid), 0);
        chk("midrst_busy", 128'(busy), 0);
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_stale", 128'(seen), 0);

        cyc = 0;
        sent = 0;
        while (sent < 10000 && cyc < 60000) begin
            in_valid = $urandom_range(3) != 0;
            in_mode = $urandom_range(1) != 0;
            in_half = $urandom_range(1) != 0;
            in_a = rnd_lanes();
            in_b = rnd_lanes();
            in_w = rnd_lanes();
            out_ready = $urandom_range(3) != 0;
            #1;
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) sent++;
        end
        in_valid = 0;
        out_ready = 1;
        chk("rand_sent", 128'(sent), 10000);
        cyc = 0;
        while ((exp_q.size() != 0 || busy) && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rand_drained", 128'(exp_q.size()), 0);
        chk("rand_idle", 128'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bu_ntt_pipe.md
Name: bu_ntt_pipe

Overview:
- Parametrised, multi-lane, fully pipelined modular butterfly for the ML-KEM NTT datapath.
- Successor to the single-lane butterfly unit. Adds per-beat NTT/INTT mode, optional INTT halving, valid/ready flow control with backpressure, and a configurable lane count.
- Sits between the coefficient-memory read mux and write-back logic in the NTT core; the controller streams (A, B, W) triples and collects (A', B') pairs.

Parameters:
- LANES, 1, number of independent butterflies processed per beat (all share one handshake)
- DW, 12, coefficient width in bits
- Q, 3329, prime modulus; must satisfy Q < 2^DW
- LATENCY, 4, fixed accepted-to-output pipeline depth in cycles; not user-changeable (localparam mirror for the testbench)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_mode  in  1  0 = NTT (Cooley-Tukey), 1 = INTT (Gentleman-Sande)
- in_half  in  1  INTT only: multiply both outputs by 2^-1 mod Q
- in_a  in  LANES*DW  A operands, lane 0 in LSBs
- in_b  in  LANES*DW  B operands
- in_w  in  LANES*DW  twiddles
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output
- out_a  out  LANES*DW  A' results
- out_b  out  LANES*DW  B' results
- out_mode  out  1  mode tag travelling with the beat
- busy  out  1  any pipeline stage holds a valid beat

Behaviour:
- Reset (sync, active-high): all stage-valid bits cleared. out_valid=0, busy=0, out_a=out_b=0, out_mode=0, in_ready=1 on the cycle after rst is sampled high. Reset mid-stream discards every in-flight beat; no partial output is ever produced.
- Handshake: a beat transfers when in_valid && in_ready; output when out_valid && out_ready. Payload is held stable while out_valid && !out_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall, so the pipeline holds as a whole (global enable). Empty bubbles advance regardless; no bubble compression required. Beats are never dropped or reordered.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+LATENCY when no stall occurs. Throughput is 1 beat/cycle. Latency is identical for both modes.
- Stage 1: register operands and tags. In INTT mode, precompute s=(A+B) mod Q and d=(A-B) mod Q, each with a single conditional correction.
- Stage 2: product p = W*B (NTT) or W*d (INTT), width 2*DW.
- Stage 3: Barrett reduction of p with K=2*DW+2 and M=floor(2^K/Q), followed by one conditional subtract. Result lies in [0, Q).
- Stage 4, NTT: A' = (A+t) mod Q, B' = (A-t) mod Q, where t is the reduced product.
- Stage 4, INTT: A' = s, B' = t. If in_half: x even -> x/2, x odd -> (x+Q)/2, applied to both outputs.
- in_half is ignored in NTT mode.
- Operands must be < Q. Out-of-range inputs give unspecified output values, but the handshake is unaffected; the bench asserts on this.
- A beat presented while rst is high is not accepted.

Decomposition:
- ntt_pkg: Q, DW, derived Barrett K/M, INV2=1665, mode encodings MODE_NTT=0 / MODE_INTT=1, LATENCY.
- Sub-module mod_mul_barrett: 2-stage multiply plus reduce, instantiated once per lane with a shared enable.
- Lane generate loop lives in bu_ntt_pipe; control and valid pipeline are shared.

Test Plan:
- NTT, LANES=1: A=800, B=3, W=7 -> A'=821, B'=779, out_valid exactly 4 cycles after accept.
- INTT, no half: A=12, B=20, W=3 -> A'=32, B'=3305. INTT with half, same operands -> A'=16, B'=3317.
- Wrap boundary, NTT: A=B=W=3328 -> A'=0, B'=3327. INTT: A=0, B=1, W=1 -> A'=1, B'=3328.
- Backpressure: stream 10 beats of alternating mode and hold out_ready=0 for 3 cycles mid-stream. Require in_ready=0 during the stall, payload stable, all 10 results in order against the golden model, and no duplicates.
- Reset mid-operation: assert rst with 3 beats in flight. Require out_valid=0 and busy=0 the next cycle, and no stale beat emitted afterwards.
- LANES=4 random regression: 10k beats against a reference model with random in_valid/out_ready. Lanes must be independent, including per-lane mixed max/zero operands.
